// File: rtl/irom_bridge.sv
// Single-line instruction fetch bridge: holds one ROM word, fetches on a miss,
// and substitutes FAULT_WORD when the ROM fails to answer.
module irom_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] FAULT_WORD     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  output logic [31:0] i_data_read,
  output logic        i_data_valid,
  input  logic        flush,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_rdata,
  output logic        err_timeout,
  output logic [15:0] miss_count
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:2] tag_q;
  logic        tag_valid_q;
  logic [31:0] data_q;
  logic [31:0] rd_q;
  logic [31:0] rom_addr_q;
  logic [15:0] cnt_q;
  logic        stale_q;
  logic        err_q;
  logic [15:0] miss_q;
  logic        hit;
  logic        last_cycle;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^i_address[1:0];

  assign hit        = (state_q == IDLE) && tag_valid_q && (tag_q == i_address[31:2]);
  assign last_cycle = (cnt_q == CNT_LAST);

  assign i_data_valid = hit;
  // Output holds the last delivered word whenever nothing valid is presented.
  assign i_data_read  = hit ? data_q : rd_q;
  assign rom_req      = (state_q == REQ);
  assign rom_addr     = rom_addr_q;
  assign err_timeout  = err_q;
  assign miss_count   = miss_q;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!hit) state_d = REQ;
    end else begin
      if (rom_ack || last_cycle) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      data_q      <= '0;
      rd_q        <= '0;
      rom_addr_q  <= '0;
      cnt_q       <= '0;
      stale_q     <= 1'b0;
      err_q       <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hit) rd_q <= data_q;
      if (state_q == IDLE) begin
        if (flush) tag_valid_q <= 1'b0;
        if (!hit) begin
          rom_addr_q <= {i_address[31:2], 2'b00};
          cnt_q      <= '0;
          stale_q    <= 1'b0;
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
      end else begin
        // Ack wins over timeout in the same cycle; a flush seen at any point
        // of the transaction keeps the returned word from being marked valid.
        if (rom_ack) begin
          data_q      <= rom_rdata;
          tag_q       <= rom_addr_q[31:2];
          tag_valid_q <= !(stale_q || flush);
        end else if (last_cycle) begin
          data_q      <= FAULT_WORD;
          tag_q       <= rom_addr_q[31:2];
          tag_valid_q <= !(stale_q || flush);
          err_q       <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 16'd1;
          if (flush) stale_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/irom_bridge.md
IROM_BRIDGE -- requirements
Module: irom_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles rom_req may stay high without rom_ack before the fetch is aborted; legal range 1..65535.
REQ-002 Parameter FAULT_WORD, default 32'h0000_0000: instruction word returned for a timed-out fetch.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-low, reset_n.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 i_address  input  32  instruction byte address from the CPU (its PC).
REQ-007 i_data_read  output  32  instruction word for i_address.
REQ-008 i_data_valid  output  1  high when i_data_read holds the word for the current i_address.
REQ-009 flush  input  1  invalidates the held instruction word (self-modifying code / ROM swap).
REQ-010 rom_req  output  1  fetch request to the instruction ROM.
REQ-011 rom_addr  output  32  word-aligned ROM address, {line[31:2],2'b00}.
REQ-012 rom_ack  input  1  ROM returns rom_rdata this cycle; ignored while rom_req is low.
REQ-013 rom_rdata  input  32  ROM read data, sampled only when rom_req and rom_ack are both high.
REQ-014 err_timeout  output  1  sticky; set by any aborted fetch.
REQ-015 miss_count  output  16  saturating count of ROM fetches started.

Function
REQ-016 Internal state: tag[31:2], tag_valid, data[31:0], FSM {IDLE, REQ}, timeout counter, stale flag.
REQ-017 Hit = IDLE and tag_valid and tag == i_address[31:2]; i_address[1:0] ignored throughout.
REQ-018 i_data_valid = hit, combinational from registered state and i_address; i_data_read = data whenever i_data_valid is high; otherwise i_data_read holds its last value.
REQ-019 IDLE and not hit: at the next edge go to REQ, latch rom_addr from i_address, clear counter, clear stale, increment miss_count (saturate at 16'hFFFF).
REQ-020 REQ: rom_req = 1; rom_addr held stable until the transaction ends; changes on i_address are ignored until IDLE.
REQ-021 REQ and rom_ack: at that edge data <= rom_rdata, tag <= rom_addr[31:2], tag_valid <= not (stale or flush), go to IDLE.
REQ-022 REQ and no rom_ack: counter increments; when counter reaches TIMEOUT_CYCLES-1 with no ack, at that edge data <= FAULT_WORD, tag <= rom_addr[31:2], tag_valid <= not (stale or flush), err_timeout <= 1, go to IDLE; rom_req is low from the next cycle.
REQ-023 rom_ack arriving in the timeout cycle takes priority: ROM data is used and err_timeout is not set.
REQ-024 Latency: miss sampled at edge N puts rom_req high in cycle N+1; ack in cycle M (M >= N+1) gives i_data_valid in cycle M+1 when i_address still matches; a zero-wait ROM gives a 2-cycle miss.
REQ-025 A hit keeps the FSM in IDLE and issues no ROM request; rom_req is 0 in IDLE.
REQ-026 flush in IDLE: tag_valid <= 0 at that edge; i_data_valid drops in the following cycle.
REQ-027 flush in REQ: stale <= 1; the transaction completes on the bus but its word is not marked valid, so a refetch follows.
REQ-028 i_address that no longer matches the fetched line when the FSM returns to IDLE starts a new miss at the next edge; no data is forwarded for the old address.
REQ-029 Exactly one outstanding ROM request; rom_req never falls without ack or timeout.

Reset
REQ-030 reset_n low at an edge: FSM IDLE, tag_valid 0, stale 0, counter 0, data 32'h0, err_timeout 0, miss_count 0; outputs i_data_valid 0, rom_req 0, rom_addr 32'h0, i_data_read 32'h0.
REQ-031 Reset during REQ aborts the fetch immediately; a rom_ack in the reset cycle is ignored.
REQ-032 Only reset clears err_timeout and miss_count.

Verification
REQ-033 Zero-wait ROM, i_address=0x100 after reset -> rom_req in cycle 1 with rom_addr 0x100, ack same cycle, i_data_valid with ROM word in cycle 2, miss_count=1.
REQ-034 Hold i_address=0x100, then 0x102 -> i_data_valid stays 1, no new rom_req, miss_count unchanged.
REQ-035 ROM acks after 3 wait cycles; i_address changes to 0x200 mid-request -> rom_addr stays 0x100 until ack, then second request to 0x200, miss_count=2.
REQ-036 TIMEOUT_CYCLES=4, ROM never acks -> rom_req high exactly 4 cycles, i_data_read=FAULT_WORD valid next cycle, err_timeout=1.
REQ-037 flush pulsed during REQ for 0x300 -> ack completes, i_data_valid stays 0, refetch of 0x300 issued, second word delivered.
REQ-038 reset_n low during REQ with ack in the same cycle -> all outputs at reset values the next cycle, no valid data.
